// File: rtl/dbg_reg_ctrl_pkg.sv
// dbg_reg_ctrl_pkg: shared constants for the debug register controller.
//   - command opcodes (3 bits); opcode 7 is deliberately left undefined
//   - FSM state encoding
//   - default register-port widths and the delay counter width
package dbg_reg_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_REG_DATA_WIDTH = 32;
  localparam int DBG_OP_W           = 3;
  localparam int CNT_W              = 4;

  localparam logic [DBG_OP_W-1:0] DBG_OP_NOP    = 3'd0;
  localparam logic [DBG_OP_W-1:0] DBG_OP_READ   = 3'd1;
  localparam logic [DBG_OP_W-1:0] DBG_OP_WRITE  = 3'd2;
  localparam logic [DBG_OP_W-1:0] DBG_OP_HALT   = 3'd3;
  localparam logic [DBG_OP_W-1:0] DBG_OP_RESUME = 3'd4;
  localparam logic [DBG_OP_W-1:0] DBG_OP_RESET  = 3'd5;
  localparam logic [DBG_OP_W-1:0] DBG_OP_STATUS = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_REG_RD    = 3'd2,
    S_REG_WR    = 3'd3,
    S_RST_PULSE = 3'd4,
    S_RESP      = 3'd5
  } dbg_state_e;

endpackage

// File: rtl/dbg_reg_ctrl_if.sv
// dbg_reg_ctrl_if: command and response channels between the debug
// transport (master) and dbg_reg_ctrl (slave). Both are valid/ready.
//   cmd_*: valid, ready, op, addr, data      (transport -> controller)
//   rsp_*: valid, ready, data, err           (controller -> transport)
interface dbg_reg_ctrl_if
  import dbg_reg_ctrl_pkg::*;
#(
  parameter int AW = DEF_REG_ADDR_WIDTH,
  parameter int DW = DEF_REG_DATA_WIDTH
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [DBG_OP_W-1:0] cmd_op;
  logic [AW-1:0]       cmd_addr;
  logic [DW-1:0]       cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dbg_delay_cnt.sv
// dbg_delay_cnt: loadable 4-bit down-counter used for the halt settle
// time and the PC-reset pulse width.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority)
//   load_val_i   : start value
//   last_o       : counter holds 1, i.e. it reaches 0 on this edge
module dbg_delay_cnt
  import dbg_reg_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Flagging at 1 lets the FSM leave its wait state on the same edge the
  // count hits 0, so a load of N yields exactly N wait cycles.
  assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/dbg_reg_ctrl.sv
// dbg_reg_ctrl: debug-side initiator for the core register/control port.
// Takes one command at a time from the transport, sequences halt, resume,
// PC reset and GPR read/write, and returns one response per command.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : command / response channels
//   jtag_reg_addr_o   : GPR index to core (0 outside register access)
//   jtag_reg_data_o   : GPR write data to core (0 outside register access)
//   jtag_reg_we_o     : one-cycle GPR write strobe
//   jtag_reg_data_i   : GPR read data from core (combinational on address)
//   jtag_halt_flag_o  : level halt request, held until RESUME or rst
//   jtag_reset_flag_o : PC reset request, RESET_CYCLES long
// HALT_SETTLE and RESET_CYCLES must lie in 1..15.
module dbg_reg_ctrl
  import dbg_reg_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int HALT_SETTLE    = 4,
  parameter int RESET_CYCLES   = 2
)(
  input  logic                      clk,
  input  logic                      rst,
  dbg_reg_ctrl_if.slave             bus,
  output logic [REG_ADDR_WIDTH-1:0] jtag_reg_addr_o,
  output logic [REG_DATA_WIDTH-1:0] jtag_reg_data_o,
  output logic                      jtag_reg_we_o,
  input  logic [REG_DATA_WIDTH-1:0] jtag_reg_data_i,
  output logic                      jtag_halt_flag_o,
  output logic                      jtag_reset_flag_o
);
  dbg_state_e                state_q, state_d;
  logic                      halted_q, halted_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [REG_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DATA_WIDTH-1:0] reg_data_q, reg_data_d;
  logic                      reg_we_q, reg_we_d;
  logic                      halt_flag_q, halt_flag_d;
  logic                      reset_flag_q, reset_flag_d;

  logic             cnt_load, cnt_last, accept;
  logic [CNT_W-1:0] cnt_val;

  dbg_delay_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .last_o     (cnt_last)
  );

  // cmd_ready is registered so it is 0 while rst is held; it rises the
  // cycle after reset releases and whenever the FSM re-enters IDLE.
  assign accept = cmd_ready_q & bus.cmd_valid;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    reg_we_d     = reg_we_q;
    halt_flag_d  = halt_flag_q;
    reset_flag_d = reset_flag_q;
    cnt_load     = 1'b0;
    cnt_val      = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          // Most opcodes answer immediately; multi-cycle ones override.
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          case (bus.cmd_op)
            DBG_OP_NOP: ;
            DBG_OP_READ: begin
              if (halted_q) begin
                state_d     = S_REG_RD;
                rsp_valid_d = 1'b0;
                reg_addr_d  = bus.cmd_addr;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            DBG_OP_WRITE: begin
              if (halted_q) begin
                state_d     = S_REG_WR;
                rsp_valid_d = 1'b0;
                reg_addr_d  = bus.cmd_addr;
                reg_data_d  = bus.cmd_data;
                reg_we_d    = 1'b1;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            DBG_OP_HALT: begin
              halt_flag_d = 1'b1;
              if (!halted_q) begin
                state_d     = S_HALT_WAIT;
                rsp_valid_d = 1'b0;
                cnt_load    = 1'b1;
                cnt_val     = CNT_W'(HALT_SETTLE);
              end
            end
            DBG_OP_RESUME: begin
              halt_flag_d = 1'b0;
              halted_d    = 1'b0;
            end
            DBG_OP_RESET: begin
              state_d      = S_RST_PULSE;
              rsp_valid_d  = 1'b0;
              reset_flag_d = 1'b1;
              cnt_load     = 1'b1;
              cnt_val      = CNT_W'(RESET_CYCLES);
            end
            DBG_OP_STATUS: rsp_data_d = REG_DATA_WIDTH'({reset_flag_q, halted_q});
            default:       rsp_err_d  = 1'b1;
          endcase
        end
      end
      S_REG_RD: begin
        rsp_data_d  = jtag_reg_data_i;
        reg_addr_d  = '0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_REG_WR: begin
        reg_addr_d  = '0;
        reg_data_d  = '0;
        reg_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_HALT_WAIT: begin
        if (cnt_last) begin
          halted_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RST_PULSE: begin
        if (cnt_last) begin
          reset_flag_d = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      halted_q     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      reg_we_q     <= 1'b0;
      halt_flag_q  <= 1'b0;
      reset_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      reg_we_q     <= reg_we_d;
      halt_flag_q  <= halt_flag_d;
      reset_flag_q <= reset_flag_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign jtag_reg_addr_o   = reg_addr_q;
  assign jtag_reg_data_o   = reg_data_q;
  assign jtag_reg_we_o     = reg_we_q;
  assign jtag_halt_flag_o  = halt_flag_q;
  assign jtag_reset_flag_o = reset_flag_q;
endmodule

// File: tb/tb_dbg_reg_ctrl.sv
module tb_dbg_reg_ctrl;
  import dbg_reg_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int HS = 4;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] jtag_reg_addr;
  logic [DW-1:0] jtag_reg_wdata, jtag_reg_rdata;
  logic          jtag_reg_we, jtag_halt_flag, jtag_reset_flag;

  dbg_reg_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  dbg_reg_ctrl #(
    .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW),
    .HALT_SETTLE(HS), .RESET_CYCLES(RC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .jtag_reg_addr_o   (jtag_reg_addr),
    .jtag_reg_data_o   (jtag_reg_wdata),
    .jtag_reg_we_o     (jtag_reg_we),
    .jtag_reg_data_i   (jtag_reg_rdata),
    .jtag_halt_flag_o  (jtag_halt_flag),
    .jtag_reset_flag_o (jtag_reset_flag)
  );

  always #5 clk = ~clk;

  // Small core register file model.
  logic [DW-1:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf[3] <= 32'h1234_5678;
    end else if (jtag_reg_we) begin
      rf[jtag_reg_addr] <= jtag_reg_wdata;
    end
  end
  assign jtag_reg_rdata = rf[jtag_reg_addr];

  // Monitors sampled mid-cycle.
  int            cyc = 0;
  int            we_cnt = 0, rf_cnt = 0;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (jtag_reg_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = jtag_reg_addr;
      we_data = jtag_reg_wdata;
    end
    if (jtag_reset_flag) rf_cnt = rf_cnt + 1;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;
  int t_acc;

  // Drive one command and push its expected response; t_acc is the
  // cycle of the accept edge, so a response seen at the very next sample
  // point has latency 1.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] ed,
                      input logic ee, input int el);
    int w = 0;
    exp_t e;
    while (bus.cmd_ready !== 1'b1 && w < 30) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 30) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_ready_timeout: op=%0d never accepted", op);
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
    @(posedge clk); #1;
    t_acc = cyc;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    e.data = ed; e.err = ee; e.lat = el;
    sb.push_back(e);
  endtask

  // Wait for a response and consume it with rsp_ready on the first
  // valid cycle; returns what was observed.
  task automatic get_rsp(output logic [DW-1:0] d, output logic e,
                         output int lat, output logic to);
    int w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    to  = (w >= 40);
    d   = bus.rsp_data;
    e   = bus.rsp_err;
    lat = cyc - t_acc + 1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          re, rto;
  int            rl;
  exp_t          ex;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, jtag_reg_addr,
         jtag_reg_wdata, jtag_reg_we, jtag_halt_flag, jtag_reset_flag} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h re=%b a=%h d=%h we=%b h=%b r=%b",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, jtag_reg_addr,
               jtag_reg_wdata, jtag_reg_we, jtag_halt_flag, jtag_reset_flag);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read_unhalted();
    int wb = we_cnt;
    send(DBG_OP_READ, 5'd5, '0, '0, 1'b1, 1);
    get_rsp(rd, re, rl, rto);
    ex = sb.pop_front();
    n_cmp++;
    if (rto || rd !== ex.data || re !== ex.err || rl != ex.lat) begin
      n_err++;
      $display("FAIL read_unhalted: got d=%h e=%b lat=%0d to=%b want d=%h e=%b lat=%0d",
               rd, re, rl, rto, ex.data, ex.err, ex.lat);
    end
    n_cmp++;
    if (we_cnt != wb) begin
      n_err++; $display("FAIL read_unhalted_we: got %0d strobes want 0", we_cnt - wb);
    end
  endtask

  task automatic test_halt_write_read();
    int wb;
    send(DBG_OP_HALT, '0, '0, '0, 1'b0, 1 + HS);
    n_cmp++;
    if (jtag_halt_flag !== 1'b1) begin
      n_err++; $display("FAIL halt_flag_t1: got %b want 1", jtag_halt_flag);
    end
    get_rsp(rd, re, rl, rto);
    ex = sb.pop_front();
    n_cmp++;
    if (rto || rd !== ex.data || re !== ex.err || rl != ex.lat) begin
      n_err++;
      $display("FAIL halt_rsp: got d=%h e=%b lat=%0d to=%b want d=%h e=%b lat=%0d",
               rd, re, rl, rto, ex.data, ex.err, ex.lat);
    end

    wb = we_cnt;
    send(DBG_OP_WRITE, 5'd5, 32'hDEAD_BEEF, '0, 1'b0, 2);
    get_rsp(rd, re, rl, rto);
    ex = sb.pop_front();
    n_cmp++;
    if (rto || rd !== ex.data || re !== ex.err || rl != ex.lat) begin
      n_err++;
      $display("FAIL write_rsp: got d=%h e=%b lat=%0d to=%b want d=%h e=%b lat=%0d",
               rd, re, rl, rto, ex.data, ex.err, ex.lat);
    end
    n_cmp++;
    if (we_cnt - wb != 1 || we_addr !== 5'd5 || we_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL write_strobe: got n=%0d a=%h d=%h want n=1 a=05 d=deadbeef",
               we_cnt - wb, we_addr, we_data);
    end
    n_cmp++;
    if (jtag_reg_addr !== '0 || jtag_reg_wdata !== '0 || jtag_reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL port_idle: got a=%h d=%h we=%b want 0", jtag_reg_addr,
               jtag_reg_wdata, jtag_reg_we);
    end

    send(DBG_OP_READ, 5'd5, '0, 32'hDEAD_BEEF, 1'b0, 2);
    send_read_check("read_x5");
    send(DBG_OP_READ, 5'd3, '0, 32'h1234_5678, 1'b0, 2);
    send_read_check("read_x3");
    // Halt while already halted answers straight away.
    send(DBG_OP_HALT, '0, '0, '0, 1'b0, 1);
    send_read_check("halt_again");
  endtask

  task automatic send_read_check(input string nm);
    get_rsp(rd, re, rl, rto);
    ex = sb.pop_front();
    n_cmp++;
    if (rto || rd !== ex.data || re !== ex.err || rl != ex.lat) begin
      n_err++;
      $display("FAIL %s: got d=%h e=%b lat=%0d to=%b want d=%h e=%b lat=%0d",
               nm, rd, re, rl, rto, ex.data, ex.err, ex.lat);
    end
  endtask

  task automatic test_reset_pulse();
    int rb = rf_cnt;
    send(DBG_OP_RESET, '0, '0, '0, 1'b0, RC + 1);
    send_read_check("reset_rsp");
    n_cmp++;
    if (rf_cnt - rb != RC) begin
      n_err++; $display("FAIL reset_pulse_len: got %0d want %0d", rf_cnt - rb, RC);
    end
    send(DBG_OP_STATUS, '0, '0, 32'h1, 1'b0, 1);
    send_read_check("status_halted");
    n_cmp++;
    if (jtag_halt_flag !== 1'b1) begin
      n_err++; $display("FAIL halt_kept: got %b want 1", jtag_halt_flag);
    end
  endtask

  task automatic test_backpressure();
    int            w = 0;
    logic [DW-1:0] d0;
    logic          e0, stable;
    int            l0;
    send(DBG_OP_READ, 5'd5, '0, 32'hDEAD_BEEF, 1'b0, 2);
    while (bus.rsp_valid !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    d0 = bus.rsp_data; e0 = bus.rsp_err; l0 = cyc - t_acc + 1;
    ex = sb.pop_front();
    n_cmp++;
    if (w >= 40 || d0 !== ex.data || e0 !== ex.err || l0 != ex.lat) begin
      n_err++;
      $display("FAIL bp_rsp: got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d",
               d0, e0, l0, ex.data, ex.err, ex.lat);
    end
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL bp_hold: got stable=%b want 1", stable);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b rv=%b want rdy=1 rv=0", bus.cmd_ready,
               bus.rsp_valid);
    end
  endtask

  task automatic test_rst_mid_halt();
    send(DBG_OP_RESUME, '0, '0, '0, 1'b0, 1);
    send_read_check("resume_halted");
    n_cmp++;
    if (jtag_halt_flag !== 1'b0) begin
      n_err++; $display("FAIL resume_flag: got %b want 0", jtag_halt_flag);
    end
    send(DBG_OP_HALT, '0, '0, '0, 1'b0, 1 + HS);
    void'(sb.pop_back());   // aborted by reset, never answered
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, jtag_reg_addr,
         jtag_reg_wdata, jtag_reg_we, jtag_halt_flag, jtag_reset_flag} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: rdy=%b rv=%b h=%b r=%b", bus.cmd_ready,
               bus.rsp_valid, jtag_halt_flag, jtag_reset_flag);
    end
    send(DBG_OP_STATUS, '0, '0, 32'h0, 1'b0, 1);
    send_read_check("status_after_rst");
  endtask

  task automatic test_misc();
    send(3'd7, '0, '0, '0, 1'b1, 1);
    send_read_check("illegal_op");
    send(DBG_OP_RESUME, '0, '0, '0, 1'b0, 1);
    send_read_check("resume_unhalted");
    n_cmp++;
    if (jtag_halt_flag !== 1'b0 || jtag_reset_flag !== 1'b0) begin
      n_err++;
      $display("FAIL resume_flags: got h=%b r=%b want 0 0", jtag_halt_flag, jtag_reset_flag);
    end
    send(DBG_OP_WRITE, 5'd7, 32'h5555_AAAA, '0, 1'b1, 1);
    send_read_check("write_unhalted");
  endtask

  task automatic test_back_to_back();
    int t1;
    send(DBG_OP_NOP, '0, '0, '0, 1'b0, 1);
    t1 = t_acc;
    send_read_check("b2b_nop");
    send(DBG_OP_STATUS, '0, '0, 32'h0, 1'b0, 1);
    send_read_check("b2b_status");
    n_cmp++;
    if (t_acc - t1 != 2) begin
      n_err++; $display("FAIL b2b_spacing: got %0d cycles want 2", t_acc - t1);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_read_unhalted();
    test_halt_write_read();
    test_reset_pulse();
    test_backpressure();
    test_rst_mid_halt();
    test_misc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
